// File: rtl/hood_mode_if.sv
// Front-panel button levels in, indicator/display state out, for hood_mode_fsm.
interface hood_mode_if;
    logic       btn_power;
    logic       btn_menu;
    logic       btn_level1;
    logic       btn_level2;
    logic       btn_level3;
    logic       btn_clean;
    logic [2:0] state;
    logic [7:0] countdown;
    logic       third_used;

    modport master (
        output btn_power, btn_menu, btn_level1, btn_level2, btn_level3, btn_clean,
        input  state, countdown, third_used
    );

    modport slave (
        input  btn_power, btn_menu, btn_level1, btn_level2, btn_level3, btn_clean,
        output state, countdown, third_used
    );
endinterface

// File: rtl/hood_mode_fsm.sv
// Range-hood mode controller: power/menu/level/self-clean FSM with 1 s tick and countdowns.
// Define POWER_LONG_PRESS_EN to require a held power press (LONG_SECS) to switch off.
module hood_mode_fsm #(
    parameter int unsigned TICK_CYCLES = 100_000_000,
    parameter int unsigned THIRD_SECS  = 60,
    parameter int unsigned CLEAN_SECS  = 180
`ifdef POWER_LONG_PRESS_EN
    ,
    parameter int unsigned LONG_SECS   = 3
`endif
) (
    input  logic       clk,
    input  logic       rst,
    hood_mode_if.slave bus
);
    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BTN_W  = 6;

    typedef enum logic [2:0] {
        S_OFF      = 3'b000,
        S_STANDBY  = 3'b001,
        S_MODE_SEL = 3'b010,
        S_FIRST    = 3'b011,
        S_SECOND   = 3'b100,
        S_THIRD    = 3'b101,
        S_CLEAN    = 3'b110
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                used_q, used_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [BTN_W-1:0]    btn, btn_q, rise;
    logic                pwr_rise, menu_rise, l1_rise, l2_rise, l3_rise, clean_rise;
    logic                tick_done;
    logic                power_off;

`ifdef POWER_LONG_PRESS_EN
    localparam int unsigned HOLD_CYCLES = LONG_SECS * TICK_CYCLES;
    logic [31:0]         hold_q, hold_d;
`endif

    assign btn  = {bus.btn_clean, bus.btn_level3, bus.btn_level2,
                   bus.btn_level1, bus.btn_menu, bus.btn_power};
    assign rise = btn & ~btn_q;
    assign {clean_rise, l3_rise, l2_rise, l1_rise, menu_rise, pwr_rise} = rise;

    assign tick_done = (tick_q == TICK_W'(TICK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            used_q  <= 1'b0;
            tick_q  <= '0;
            btn_q   <= '0;
`ifdef POWER_LONG_PRESS_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            used_q  <= used_d;
            tick_q  <= tick_d;
            btn_q   <= btn;
`ifdef POWER_LONG_PRESS_EN
            hold_q  <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        used_d    = used_q;
        tick_d    = tick_q;
        power_off = 1'b0;
`ifdef POWER_LONG_PRESS_EN
        // Hold only counts from a fresh press while on, so the power-on press cannot switch back off.
        hold_d = '0;
        if ((state_q != S_OFF) && bus.btn_power && (pwr_rise || (hold_q != '0))) begin
            if (hold_q == 32'(HOLD_CYCLES - 1)) begin
                power_off = 1'b1;
            end else begin
                hold_d = hold_q + 32'(1);
            end
        end
`else
        power_off = (state_q != S_OFF) && pwr_rise;
`endif

        if (power_off) begin
            state_d = S_OFF;
            cnt_d   = '0;
            used_d  = 1'b0;
            tick_d  = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (pwr_rise) state_d = S_STANDBY;
                end
                S_STANDBY: begin
                    if (menu_rise) state_d = S_MODE_SEL;
                end
                S_MODE_SEL: begin
                    if (l1_rise) begin
                        state_d = S_FIRST;
                    end else if (l2_rise) begin
                        state_d = S_SECOND;
                    end else if (l3_rise && !used_q) begin
                        state_d = S_THIRD;
                        used_d  = 1'b1;
                        cnt_d   = CNT_W'(THIRD_SECS);
                        tick_d  = '0;
                    end else if (clean_rise) begin
                        state_d = S_CLEAN;
                        cnt_d   = CNT_W'(CLEAN_SECS);
                        tick_d  = '0;
                    end else if (menu_rise) begin
                        state_d = S_STANDBY;
                    end
                end
                S_FIRST, S_SECOND: begin
                    if (l1_rise) begin
                        state_d = S_FIRST;
                    end else if (l2_rise) begin
                        state_d = S_SECOND;
                    end else if (menu_rise) begin
                        state_d = S_STANDBY;
                    end
                end
                S_THIRD, S_CLEAN: begin
                    // Last decrement and exit share one edge; countdown saturates at 0.
                    if (tick_done) begin
                        tick_d = '0;
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_d   = '0;
                            state_d = (state_q == S_THIRD) ? S_SECOND : S_STANDBY;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                default: begin
                    state_d = S_OFF;
                end
            endcase
        end
    end

    assign bus.state      = state_q;
    assign bus.countdown  = cnt_q;
    assign bus.third_used = used_q;
endmodule

// File: doc/hood_mode_fsm.md
# hood_mode_fsm

Main range-hood control state machine: turns debounced front-panel buttons into the 3-bit system `state` code that the power/working indicators and display decode. It tracks power, menu, three suction levels and self-clean. It also runs the one-second tick, the third-level and self-clean countdowns, and the once-per-power-cycle third-level lockout. It sits between the button debouncers and every downstream state decoder.

## Interface
- `TICK_CYCLES`, default 100_000_000: clock cycles per 1 s tick (100 MHz board); benches use 10.
- `THIRD_SECS`, default 60: third-level run time in seconds.
- `CLEAN_SECS`, default 180: self-clean run time in seconds.
- `LONG_SECS`, default 3: power-off hold time in seconds; used only with `POWER_LONG_PRESS_EN`.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous and active-high; one clock, all state below.
- `btn_power` input 1: debounced power button level.
- `btn_menu` input 1: debounced menu button level.
- `btn_level1`, `btn_level2`, `btn_level3` input 1 each: debounced level-select button levels.
- `btn_clean` input 1: debounced self-clean button level.
- `state` output 3: OFF=000, STANDBY=001, MODE_SELECT=010, FIRST_LEVEL=011, SECOND_LEVEL=100, THIRD_LEVEL=101, SELF_CLEAN=110; 111 is never driven.
- `countdown` output 8: seconds remaining in THIRD_LEVEL or SELF_CLEAN; 0 in all other states.
- `third_used` output 1: third level already used this power cycle.

## Operation
- Each button has a registered previous-level copy. The block acts only on rising edges (`btn & ~btn_q`). A held button never retriggers.
- Power handling has top priority in every state.
  - OFF: a power edge moves to STANDBY.
  - Any other state: power-off goes to OFF (see Configuration). Going to OFF clears `countdown`, `third_used` and the tick counter.
- STANDBY: a menu edge moves to MODE_SELECT. All other buttons are ignored.
- MODE_SELECT: the first matching edge wins, in this priority:
  - level1 → FIRST_LEVEL.
  - level2 → SECOND_LEVEL.
  - level3 → THIRD_LEVEL, only when `third_used`=0. This sets `third_used`=1 and loads `countdown`=THIRD_SECS. When `third_used`=1, level3 is ignored and the block stays in MODE_SELECT.
  - clean → SELF_CLEAN, loads `countdown`=CLEAN_SECS.
  - menu → STANDBY.
- FIRST_LEVEL / SECOND_LEVEL:
  - level1 and level2 edges switch between the two; an edge for the current level is a no-op.
  - A menu edge moves to STANDBY.
  - level3 and clean are ignored.
- THIRD_LEVEL: all buttons except power are ignored. When `countdown` reaches 0 the block moves to SECOND_LEVEL.
- SELF_CLEAN: all buttons except power are ignored. When `countdown` reaches 0 the block moves to STANDBY.
- Tick counter: runs 0..TICK_CYCLES-1 only in THIRD_LEVEL and SELF_CLEAN.
  - It is cleared on entry to either state, so the first second is a full second.
  - At terminal count, `countdown` decrements by 1.
  - The step from 1 to 0 and the state exit happen on the same edge. `countdown` never wraps below 0.
- If several button edges arrive in one cycle, power wins, then the MODE_SELECT priority above applies. Edges not taken are dropped, not queued.

## Timing
- Reset values: `state`=000, `countdown`=0, `third_used`=0, edge registers=0. A button already high at reset release counts as a rising edge in the first cycle.
- Latency is one cycle: if a button is sampled high at edge N with `btn_q` low, `state` shows the new value after edge N.
- THIRD_LEVEL lasts exactly THIRD_SECS×TICK_CYCLES cycles from the entry edge to the exit edge. SELF_CLEAN lasts exactly CLEAN_SECS×TICK_CYCLES cycles.
- `countdown` updates on the same edge as the tick terminal count.
- Reset asserted mid-countdown takes priority over every transition on that edge.

## Configuration
- `POWER_LONG_PRESS_EN` defined:
  - In a non-OFF state, `btn_power` must be held high for LONG_SECS×TICK_CYCLES consecutive cycles to go to OFF.
  - Releasing early clears the hold counter, and the state is unchanged.
  - After turning off, power-on needs a fresh rising edge, so a held button does not power back on.
- `POWER_LONG_PRESS_EN` undefined: any power rising edge in a non-OFF state goes to OFF immediately. The hold counter is not built.

## Test plan
All scenarios use `TICK_CYCLES`=10, `THIRD_SECS`=3, `CLEAN_SECS`=4.
- Reset, then pulse power, then menu, then level2 → `state` goes 000→001→010→100, each one cycle after its edge; `countdown` stays 0.
- From MODE_SELECT pulse level3 → `state`=101 and `countdown`=3, then 2/1/0 at 10-cycle steps; after exactly 30 cycles `state`=100. Then menu, menu, level3 → `state` stays 010.
- Pulse clean from MODE_SELECT → `state`=110, `countdown` 4→0 over 40 cycles, then `state`=001; a level1 pulse mid-clean changes nothing.
- level1 and menu rising in the same cycle in MODE_SELECT → `state`=011; then power plus level2 together → `state`=000 (without macro), `third_used`=0.
- With `POWER_LONG_PRESS_EN`: hold power 29 cycles in FIRST_LEVEL → stays 011; hold 30 cycles → 000 and stays 000 while the button is still held.
- Assert `rst` at `countdown`=2 in THIRD_LEVEL → the next cycle shows `state`=000, `countdown`=0, `third_used`=0.
